ccc_phase_ctrl: RTL and testbench
=================================

# ccc_phase_ctrl

Sequencer for the fabric PLL clock conditioning circuit (the CCC that feeds the DDR3 interface). It brings the PLL out of power-down and qualifies lock. It then serves dynamic phase-shift requests by driving the PLL phase-select, direction, rotate and load-phase pins with the required pulse spacing, and tracks the cumulative phase position of OUT0/OUT2/OUT3. It sits between the DDR3 training/calibration logic and the CCC instance.

## Interface
- PD_CYCLES, 16: cycles PLL_POWERDOWN_N is held low after reset.
- LOCK_FILTER, 8: consecutive synchronized lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 4096: cycles allowed for lock before LOCK_ERR.
- ROT_GAP, 4: idle cycles after each PHASE_ROTATE pulse.
- STEP_W, 6: width of the step-count request.
- POS_W, 8: width of each tracked phase position (wraps modulo 2^POS_W).
- CLK  in  1  system clock; all logic is synchronous to it.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  phase-shift request valid.
- REQ_SEL  in  3  output mask {OUT3, OUT2, OUT0}.
- REQ_DIR  in  1  1 = advance (+1 per step), 0 = retard (−1 per step).
- REQ_STEPS  in  STEP_W  number of rotate steps.
- REQ_READY  out  1  controller idle and locked; the request is accepted on REQ_VALID&&REQ_READY.
- DONE  out  1  one-cycle completion pulse.
- DONE_ERR  out  1  qualifies DONE: operation aborted by lock loss.
- LOCKED  out  1  filtered lock status.
- LOCK_ERR  out  1  sticky lock-timeout flag; cleared only by RESET.
- POS_OUT0, POS_OUT2, POS_OUT3  out  POS_W each  cumulative phase position.
- PLL_LOCK  in  1  raw PLL lock (asynchronous; synchronized internally).
- PLL_POWERDOWN_N, PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL, PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N  out  1 each  to CCC.

## Operation
- PLL_LOCK passes through a 2-flop synchronizer; the filter and timeout counters use the synchronized value.
- States: PWRDN → WAIT_LOCK → IDLE → ROTATE ↔ GAP → LOAD → IDLE; ERROR.
- PWRDN: PLL_POWERDOWN_N=0 for PD_CYCLES, then 1, then go to WAIT_LOCK.
- WAIT_LOCK: a filter counter counts consecutive lock-high cycles and resets on any low. At LOCK_FILTER, set LOCKED=1 and go to IDLE. A timeout counter reaching LOCK_TIMEOUT sets LOCK_ERR and goes to ERROR.
- ERROR is terminal until RESET. PLL_POWERDOWN_N stays 1 and REQ_READY stays 0.
- IDLE: REQ_READY=1. On accept, capture SEL, DIR and STEPS.
  - Accept with STEPS=0: DONE pulses next cycle, no PLL pin activity, positions unchanged.
  - Accept with SEL=0: same as STEPS=0.
- ROTATE: PHASE_ROTATE=1 for one cycle. Every selected POS_OUTx is incremented or decremented by 1 (modulo 2^POS_W). The step counter decrements. Go to GAP.
- GAP: ROT_GAP cycles. Then go to ROTATE if steps remain, else LOAD.
- LOAD: LOAD_PHASE_N=0 for one cycle. DONE=1 on the following cycle in IDLE.
- PHASE_OUTx_SEL and PHASE_DIRECTION are driven from the captured request. They are stable from the accept cycle +1 through the LOAD cycle, and return to 0 in IDLE.
- Lock loss (synchronized lock low) in IDLE, ROTATE, GAP or LOAD:
  - LOCKED→0.
  - Any in-flight op ends with DONE=1, DONE_ERR=1; LOAD is not issued and positions keep the steps already applied.
  - Controller restarts at PWRDN.
- Positions reset to 0 on RESET and on every PWRDN entry, since a PLL restart zeroes phase.

## Timing
- Reset values: PLL_POWERDOWN_N=0, LOAD_PHASE_N=1, all other outputs 0, state PWRDN.
- Request accepted at cycle t: first PHASE_ROTATE at t+1; step k pulses at t+1+k·(ROT_GAP+1).
- Last GAP ends, then LOAD_PHASE_N=0 at t+1+N·(ROT_GAP+1), then DONE at t+2+N·(ROT_GAP+1).
- REQ_READY falls the cycle after accept and rises together with DONE.
- REQ_VALID held during busy is ignored and not queued.
- A REQ_VALID and lock loss in the same IDLE cycle: lock loss wins and the request is not accepted.

## Structure
- Shared package ccc_ctrl_pkg holds the state enum and the REQ_SEL bit indices (SEL_OUT0=0, SEL_OUT2=1, SEL_OUT3=2).
- Sub-module ccc_lock_qual covers the synchronizer, filter counter and timeout counter, with outputs locked, lost and timeout.

## Test plan
- Reset, PLL_LOCK rises at cycle 30 → POWERDOWN_N=1 at cycle 16; LOCKED=1 after 8 synchronized high cycles plus 2 sync cycles; REQ_READY=1.
- SEL=3'b101, DIR=1, STEPS=3, ROT_GAP=4 → ROTATE pulses at t+1, t+6, t+11; LOAD_PHASE_N low at t+16; DONE at t+17; POS_OUT0=3, POS_OUT3=3, POS_OUT2=0.
- POS_OUT2=1, then SEL=3'b010, DIR=0, STEPS=2 → POS_OUT2=255 (wrap), DONE_ERR=0.
- STEPS=0 → DONE one cycle after accept; no ROTATE or LOAD pulse.
- Lock drops after the 2nd of 5 steps → DONE with DONE_ERR=1, no LOAD, POWERDOWN_N=0 for 16 cycles, positions cleared, relock resumes.
- PLL_LOCK held low → LOCK_ERR=1 at cycle PD_CYCLES+4096; REQ_READY stays 0 until RESET.

Source files
------------

// File: rtl/ccc_ctrl_pkg.sv
// Shared types for the CCC phase controller: sequencer states and REQ_SEL bit positions.
package ccc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN,
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_ROTATE,
        ST_GAP,
        ST_LOAD,
        ST_ERROR
    } state_t;

    localparam int SEL_W    = 3;
    localparam int SEL_OUT0 = 0;
    localparam int SEL_OUT2 = 1;
    localparam int SEL_OUT3 = 2;

endpackage

// File: rtl/ccc_lock_qual.sv
// PLL lock qualifier: 2-flop synchronizer, consecutive-high filter and lock timeout.
// While holding lock, it reports loss as soon as the synchronized lock goes low.
module ccc_lock_qual #(
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic wait_lock,
    output logic locked,
    output logic lost,
    output logic timeout
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    logic              sync1;
    logic              sync2;
    logic [FILT_W-1:0] filt_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              hunting;
    logic              filter_hit;

    assign hunting    = wait_lock && !locked;
    assign filter_hit = hunting && sync2 && (filt_cnt == FILT_W'(LOCK_FILTER - 1));
    // A lock that qualifies on the very last allowed cycle still counts as a lock.
    assign timeout    = hunting && !filter_hit && (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
    assign lost       = locked && !sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filt_cnt <= '0;
            tmo_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep sync1/sync2 a real two-stage shift.
            sync1    <= pll_lock;
            sync2    <= sync1;
            filt_cnt <= (hunting && sync2 && !filter_hit) ? filt_cnt + FILT_W'(1) : '0;
            tmo_cnt  <= hunting ? tmo_cnt + TMO_W'(1) : '0;
            if (lost)
                locked <= 1'b0;
            else if (filter_hit)
                locked <= 1'b1;
        end
    end

endmodule

// File: rtl/ccc_phase_ctrl.sv
// CCC PLL sequencer: power-up and lock qualification, paced dynamic phase rotation,
// and tracking of the cumulative OUT0/OUT2/OUT3 phase positions.
module ccc_phase_ctrl
    import ccc_ctrl_pkg::*;
#(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int ROT_GAP      = 4,    // must be >= 1
    parameter int STEP_W       = 6,
    parameter int POS_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              req_ready,
    output logic              done,
    output logic              done_err,
    output logic              locked,
    output logic              lock_err,
    output logic [POS_W-1:0]  pos_out0,
    output logic [POS_W-1:0]  pos_out2,
    output logic [POS_W-1:0]  pos_out3,
    input  logic              pll_lock,
    output logic              pll_powerdown_n,
    output logic              phase_out0_sel,
    output logic              phase_out2_sel,
    output logic              phase_out3_sel,
    output logic              phase_direction,
    output logic              phase_rotate,
    output logic              load_phase_n
);

    localparam int PD_W  = $clog2(PD_CYCLES + 1);
    localparam int GAP_W = $clog2(ROT_GAP + 1);

    state_t             state;
    logic [PD_W-1:0]    pd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STEP_W-1:0]  steps_left;
    logic [SEL_W-1:0]   sel_q;
    logic               dir_q;
    logic [POS_W-1:0]   pos [SEL_W];
    logic               lost;
    logic               timeout;

    ccc_lock_qual #(
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_qual (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .wait_lock (state == ST_WAIT_LOCK),
        .locked    (locked),
        .lost      (lost),
        .timeout   (timeout)
    );

    assign phase_out0_sel  = sel_q[SEL_OUT0];
    assign phase_out2_sel  = sel_q[SEL_OUT2];
    assign phase_out3_sel  = sel_q[SEL_OUT3];
    assign phase_direction = dir_q;
    assign pos_out0        = pos[SEL_OUT0];
    assign pos_out2        = pos[SEL_OUT2];
    assign pos_out3        = pos[SEL_OUT3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_PWRDN;
            pd_cnt          <= '0;
            gap_cnt         <= '0;
            steps_left      <= '0;
            sel_q           <= '0;
            dir_q           <= 1'b0;
            // NOTE: the position array is architectural state, so every entry is reset.
            for (int i = 0; i < SEL_W; i++) pos[i] <= '0;
            pll_powerdown_n <= 1'b0;
            load_phase_n    <= 1'b1;
            phase_rotate    <= 1'b0;
            req_ready       <= 1'b0;
            done            <= 1'b0;
            done_err        <= 1'b0;
            lock_err        <= 1'b0;
        end else begin
            done         <= 1'b0;
            done_err     <= 1'b0;
            phase_rotate <= 1'b0;
            load_phase_n <= 1'b1;

            case (state)
                ST_PWRDN: begin
                    if (pd_cnt == PD_W'(PD_CYCLES - 1)) begin
                        pll_powerdown_n <= 1'b1;
                        state           <= ST_WAIT_LOCK;
                    end else begin
                        pd_cnt <= pd_cnt + PD_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (timeout) begin
                        lock_err <= 1'b1;
                        state    <= ST_ERROR;
                    end else if (locked && !lost) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        // An empty mask or zero steps completes at once without touching the PLL.
                        if (req_sel == '0 || req_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            sel_q        <= req_sel;
                            dir_q        <= req_dir;
                            steps_left   <= req_steps;
                            req_ready    <= 1'b0;
                            phase_rotate <= 1'b1;
                            state        <= ST_ROTATE;
                        end
                    end
                end
                ST_ROTATE: begin
                    for (int i = 0; i < SEL_W; i++) begin
                        if (sel_q[i])
                            pos[i] <= dir_q ? pos[i] + POS_W'(1) : pos[i] - POS_W'(1);
                    end
                    steps_left <= steps_left - STEP_W'(1);
                    gap_cnt    <= '0;
                    state      <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(ROT_GAP - 1)) begin
                        if (steps_left != '0) begin
                            phase_rotate <= 1'b1;
                            state        <= ST_ROTATE;
                        end else begin
                            load_phase_n <= 1'b0;
                            state        <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_LOAD: begin
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                    sel_q     <= '0;
                    dir_q     <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_PWRDN;
                end
            endcase

            // Lock loss overrides whatever the state logic chose, including a same-cycle accept.
            if (lost && state inside {ST_IDLE, ST_ROTATE, ST_GAP, ST_LOAD}) begin
                done            <= (state != ST_IDLE);
                done_err        <= (state != ST_IDLE);
                req_ready       <= 1'b0;
                phase_rotate    <= 1'b0;
                load_phase_n    <= 1'b1;
                sel_q           <= '0;
                dir_q           <= 1'b0;
                pll_powerdown_n <= 1'b0;
                pd_cnt          <= '0;
                for (int i = 0; i < SEL_W; i++) pos[i] <= '0;
                state           <= ST_PWRDN;
            end
        end
    end

endmodule

// File: tb/tb_ccc_phase_ctrl.sv
// Randomized scoreboard bench for ccc_phase_ctrl: the driver queues expected pulses and
// completions from a step-count model, and negedge monitors pop and compare them.
module tb_ccc_phase_ctrl;

    localparam int PD     = 16;
    localparam int FILT   = 8;
    localparam int TMO    = 4096;
    localparam int GAP    = 4;
    localparam int STEP_W = 6;
    localparam int POS_W  = 8;
    localparam int MASK   = (1 << POS_W) - 1;

    typedef struct {
        int lo;
        int hi;
        bit err;
        bit chk_pos;
        int p0;
        int p2;
        int p3;
    } done_t;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       dir;
    } rot_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [2:0]        req_sel = '0;
    logic              req_dir = 1'b0;
    logic [STEP_W-1:0] req_steps = '0;
    logic              pll_lock = 1'b0;
    logic              req_ready, done, done_err, locked, lock_err;
    logic [POS_W-1:0]  pos_out0, pos_out2, pos_out3;
    logic              pll_powerdown_n, phase_out0_sel, phase_out2_sel, phase_out3_sel;
    logic              phase_direction, phase_rotate, load_phase_n;

    int    cyc;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    mpos [3] = '{0, 0, 0};
    done_t done_q [$];
    rot_t  rot_q [$];
    int    load_q [$];
    done_t md;
    rot_t  mr;
    int    ml;

    ccc_phase_ctrl #(
        .PD_CYCLES    (PD),
        .LOCK_FILTER  (FILT),
        .LOCK_TIMEOUT (TMO),
        .ROT_GAP      (GAP),
        .STEP_W       (STEP_W),
        .POS_W        (POS_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_sel         (req_sel),
        .req_dir         (req_dir),
        .req_steps       (req_steps),
        .req_ready       (req_ready),
        .done            (done),
        .done_err        (done_err),
        .locked          (locked),
        .lock_err        (lock_err),
        .pos_out0        (pos_out0),
        .pos_out2        (pos_out2),
        .pos_out3        (pos_out3),
        .pll_lock        (pll_lock),
        .pll_powerdown_n (pll_powerdown_n),
        .phase_out0_sel  (phase_out0_sel),
        .phase_out2_sel  (phase_out2_sel),
        .phase_out3_sel  (phase_out3_sel),
        .phase_direction (phase_direction),
        .phase_rotate    (phase_rotate),
        .load_phase_n    (load_phase_n)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th clock edge that sees reset low.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_locked();
        int w = 0;
        while (!locked && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("relock", locked, 1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((done_q.size() != 0 || !req_ready) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("idle_timeout", done_q.size(), 0);
    endtask

    // Issue one request; abort > 0 drops PLL_LOCK right after that many rotate pulses.
    task automatic do_req(input logic [2:0] sel, input logic dir, input int steps,
                          input bit hold, input int abort);
        int    t, w, n_rot, drop;
        bit    nul;
        done_t d;
        rot_t  r;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("ready_timeout", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = STEP_W'(steps);
        t     = cyc;
        nul   = (sel == 3'b000) || (steps == 0);
        n_rot = nul ? 0 : ((abort > 0) ? abort : steps);
        drop  = t + 2 + (abort - 1) * (GAP + 1);
        for (int k = 0; k < n_rot; k++) begin
            r.cyc = t + 1 + k * (GAP + 1);
            r.sel = sel;
            r.dir = dir;
            rot_q.push_back(r);
        end
        d.err     = 1'b0;
        d.chk_pos = 1'b1;
        if (nul) begin
            d.lo = t + 1;
            d.hi = t + 1;
        end else if (abort > 0) begin
            d.lo      = drop + 2;
            d.hi      = drop + 4;
            d.err     = 1'b1;
            d.chk_pos = 1'b0;
            for (int i = 0; i < 3; i++) mpos[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (sel[i]) mpos[i] = dir ? (mpos[i] + steps) & MASK : (mpos[i] - steps) & MASK;
            load_q.push_back(t + 1 + steps * (GAP + 1));
            d.lo = t + 2 + steps * (GAP + 1);
            d.hi = d.lo;
        end
        d.p0 = mpos[0];
        d.p2 = mpos[1];
        d.p3 = mpos[2];
        done_q.push_back(d);
        @(negedge clk);
        check("ready_after_accept", req_ready, nul ? 1 : 0);
        if (hold && !nul && abort == 0) begin
            req_sel   = 3'($urandom_range(7, 0));
            req_dir   = 1'($urandom_range(1, 0));
            req_steps = STEP_W'($urandom_range(20, 0));
            repeat (2) @(negedge clk);
        end
        req_valid = 1'b0;
        if (abort > 0 && !nul) begin
            wait_cyc(drop);
            pll_lock = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (phase_rotate) begin
                if (rot_q.size() == 0) check("rot_unexpected", phase_rotate, 0);
                else begin
                    mr = rot_q.pop_front();
                    check("rot_cycle", cyc, mr.cyc);
                    check("rot_pins", {phase_out3_sel, phase_out2_sel, phase_out0_sel, phase_direction},
                          {mr.sel, mr.dir});
                end
            end
            if (!load_phase_n) begin
                if (load_q.size() == 0) check("load_unexpected", load_phase_n, 1);
                else begin
                    ml = load_q.pop_front();
                    check("load_cycle", cyc, ml);
                    check("load_pins", {phase_out3_sel, phase_out2_sel, phase_out0_sel}, mr.sel);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 0);
                else begin
                    md = done_q.pop_front();
                    if (md.lo == md.hi) check("done_cycle", cyc, md.lo);
                    else check("done_window", (cyc >= md.lo) && (cyc <= md.hi), 1);
                    check("done_err", done_err, md.err);
                    check("pins_idle", {phase_out3_sel, phase_out2_sel, phase_out0_sel, phase_direction}, 0);
                    if (md.chk_pos) begin
                        check("pos_out0", pos_out0, md.p0);
                        check("pos_out2", pos_out2, md.p2);
                        check("pos_out3", pos_out3, md.p3);
                    end
                    if (!md.err) check("ready_with_done", req_ready, 1);
                end
            end else if (done_err) begin
                check("done_err_alone", done_err, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, cnt, w;
        bit r_at_lock;
        repeat (3) @(negedge clk);
        check("rst_pd_n", pll_powerdown_n, 0);
        check("rst_load_n", load_phase_n, 1);
        check("rst_others", {req_ready, done, done_err, locked, lock_err, phase_rotate,
                             phase_out0_sel, phase_out2_sel, phase_out3_sel, phase_direction,
                             pos_out0, pos_out2, pos_out3}, 0);
        reset = 1'b0;

        // Power-up and first lock with PLL_LOCK rising at cycle 30.
        wait_cyc(PD - 1);
        check("pd_n_low_end", pll_powerdown_n, 0);
        wait_cyc(PD);
        check("pd_n_high", pll_powerdown_n, 1);
        wait_cyc(30);
        pll_lock = 1'b1;
        wait_cyc(30 + 2 + FILT - 1);
        check("locked_early", locked, 0);
        wait_cyc(30 + 2 + FILT);
        check("locked_on_time", locked, 1);
        r_at_lock = req_ready;
        @(negedge clk);
        check("ready_after_lock", r_at_lock || req_ready, 1);

        // Directed requests, including a modulo wrap, null requests and the largest step count.
        do_req(3'b101, 1'b1, 3, 1'b0, 0);
        do_req(3'b010, 1'b1, 1, 1'b0, 0);
        do_req(3'b010, 1'b0, 2, 1'b0, 0);
        do_req(3'b011, 1'b1, 0, 1'b0, 0);
        do_req(3'b000, 1'b1, 5, 1'b0, 0);
        do_req(3'b111, 1'b0, (1 << STEP_W) - 1, 1'b1, 0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            do_req(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                   ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 1)),
                   1'($urandom_range(1, 0)), 0);
        end
        wait_idle();

        // Lock lost after the second of five steps.
        do_req(3'($urandom_range(7, 1)), 1'b1, 5, 1'b0, 2);
        w = 0;
        while (pll_powerdown_n && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("pd_low_after_loss", pll_powerdown_n, 0);
        check("locked_after_loss", locked, 0);
        check("pos_cleared", {pos_out0, pos_out2, pos_out3}, 0);
        pll_lock = 1'b1;
        cnt = 0;
        while (!pll_powerdown_n && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("pd_low_len", cnt, PD);
        wait_locked();
        check("pos_after_relock", {pos_out0, pos_out2, pos_out3}, 0);
        wait_idle();

        // Request presented in the same idle cycle that lock loss is seen: must be dropped.
        @(negedge clk);
        d = cyc;
        pll_lock = 1'b0;
        wait_cyc(d + 2);
        req_valid = 1'b1;
        req_sel   = 3'b001;
        req_dir   = 1'b1;
        req_steps = STEP_W'(3);
        @(negedge clk);
        req_valid = 1'b0;
        wait_cyc(d + 4);
        check("locked_idle_loss", locked, 0);
        check("ready_idle_loss", req_ready, 0);
        for (int i = 0; i < 3; i++) mpos[i] = 0;
        pll_lock = 1'b1;
        wait_locked();
        do_req(3'b100, 1'b1, 2, 1'b0, 0);
        wait_idle();

        // Lock never arrives: sticky timeout error.
        @(negedge clk);
        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(PD + TMO - 1);
        check("lock_err_early", lock_err, 0);
        wait_cyc(PD + TMO);
        check("lock_err_set", lock_err, 1);
        check("ready_in_error", req_ready, 0);
        check("pd_n_in_error", pll_powerdown_n, 1);
        pll_lock = 1'b1;
        wait_cyc(PD + TMO + 40);
        check("lock_err_sticky", lock_err, 1);
        check("error_terminal", {req_ready, locked}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("lock_err_cleared", lock_err, 0);

        check("rot_q_drained", rot_q.size(), 0);
        check("load_q_drained", load_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
